// File: rtl/fifo_cache_mem.sv
// fifo_cache_mem: responder end of the fifo cache command/response interface.
// Serves 128-bit read/write bursts from an on-chip synchronous RAM, one burst at a time.
module fifo_cache_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fifo_cmd_valid,
  output logic         fifo_cmd_ready,
  input  logic         fifo_cmd_type,
  input  logic [26:0]  fifo_cmd_addr,
  input  logic [5:0]   fifo_cmd_burst_cnt,
  input  logic [127:0] fifo_cmd_wt_data,
  input  logic [15:0]  fifo_cmd_wt_mask,
  output logic         fifo_rsp_valid,
  input  logic         fifo_rsp_ready,
  output logic [127:0] fifo_rsp_data,
  output logic         busy
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned RCNT_W = CNT_W + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  wr_left_q;
  logic [RCNT_W-1:0] rd_left_q, rsp_left_q;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              cmd_fire_c, rsp_fire_c, rd_issue_c, wr_en_c;
  logic [ADDR_W-1:0] beat_idx_c, wr_addr_c;
  logic              unused_c;

  assign beat_idx_c = fifo_cmd_addr[ADDR_W+3:4];
  assign unused_c   = ^{fifo_cmd_addr[26:ADDR_W+4], fifo_cmd_addr[3:0]};

  assign cmd_fire_c = fifo_cmd_valid & fifo_cmd_ready;
  assign rsp_fire_c = fifo_rsp_valid & fifo_rsp_ready;
  // The RAM read lands straight in the output buffer, so nothing stays in flight past one edge.
  assign rd_issue_c = (state_q == RD) && (rd_left_q != '0) && (count_q < 2'd2);
  assign wr_en_c    = cmd_fire_c && !rst &&
                      (((state_q == IDLE) && fifo_cmd_type) || (state_q == WR));
  assign wr_addr_c  = (state_q == WR) ? wr_ptr_q : beat_idx_c;

  // Next-state and output-buffer occupancy
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire_c) begin
          if (!fifo_cmd_type) begin
            state_d = RD;
          end else if (fifo_cmd_burst_cnt != '0) begin
            state_d = WR;
          end
        end
      end
      WR: begin
        if (cmd_fire_c && (wr_left_q == CNT_W'(1))) state_d = IDLE;
      end
      RD: begin
        if (rsp_fire_c && (rsp_left_q == RCNT_W'(1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    case ({rd_issue_c, rsp_fire_c})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Byte-masked RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (!fifo_cmd_wt_mask[i]) mem[wr_addr_c][8*i +: 8] <= fifo_cmd_wt_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= 2'd0;
      fifo_cmd_ready <= 1'b1;
      fifo_rsp_valid <= 1'b0;
      fifo_rsp_data  <= '0;
      busy           <= 1'b0;
      skid_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_left_q      <= '0;
      rd_left_q      <= '0;
      rsp_left_q     <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      fifo_cmd_ready <= (state_d != RD);
      fifo_rsp_valid <= (count_d != 2'd0);
      busy           <= (state_d != IDLE) || (count_d != 2'd0);

      if ((state_q == IDLE) && cmd_fire_c) begin
        wr_ptr_q   <= beat_idx_c + ADDR_W'(1);
        rd_ptr_q   <= beat_idx_c;
        wr_left_q  <= fifo_cmd_burst_cnt;
        rd_left_q  <= RCNT_W'(fifo_cmd_burst_cnt) + RCNT_W'(1);
        rsp_left_q <= RCNT_W'(fifo_cmd_burst_cnt) + RCNT_W'(1);
      end
      if ((state_q == WR) && cmd_fire_c) begin
        wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
        wr_left_q <= wr_left_q - CNT_W'(1);
      end
      if (rd_issue_c) begin
        rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
        rd_left_q <= rd_left_q - RCNT_W'(1);
      end
      if (rsp_fire_c) rsp_left_q <= rsp_left_q - RCNT_W'(1);

      // Head entry drives the response port; the skid entry absorbs one stalled read
      case ({rd_issue_c, rsp_fire_c})
        2'b10: begin
          if (count_q == 2'd0) fifo_rsp_data <= mem[rd_ptr_q];
          else                 skid_q        <= mem[rd_ptr_q];
        end
        2'b11: fifo_rsp_data <= mem[rd_ptr_q];
        2'b01: begin
          if (count_q == 2'd2) fifo_rsp_data <= skid_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_cache_mem.sv
// tb_fifo_cache_mem: directed vectors, corner sequences and random traffic
// against a byte-level memory model for fifo_cache_mem.
module tb_fifo_cache_mem;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_cmd_valid;
  logic         fifo_cmd_ready;
  logic         fifo_cmd_type;
  logic [26:0]  fifo_cmd_addr;
  logic [5:0]   fifo_cmd_burst_cnt;
  logic [127:0] fifo_cmd_wt_data;
  logic [15:0]  fifo_cmd_wt_mask;
  logic         fifo_rsp_valid;
  logic         fifo_rsp_ready;
  logic [127:0] fifo_rsp_data;
  logic         busy;

  fifo_cache_mem #(.ADDR_W(ADDR_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .fifo_cmd_valid     (fifo_cmd_valid),
    .fifo_cmd_ready     (fifo_cmd_ready),
    .fifo_cmd_type      (fifo_cmd_type),
    .fifo_cmd_addr      (fifo_cmd_addr),
    .fifo_cmd_burst_cnt (fifo_cmd_burst_cnt),
    .fifo_cmd_wt_data   (fifo_cmd_wt_data),
    .fifo_cmd_wt_mask   (fifo_cmd_wt_mask),
    .fifo_rsp_valid     (fifo_rsp_valid),
    .fifo_rsp_ready     (fifo_rsp_ready),
    .fifo_rsp_data      (fifo_rsp_data),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  logic [127:0] ref_mem [DEPTH];
  logic [127:0] wdata_a [64];
  logic [15:0]  wmask_a [64];
  logic [127:0] exp_a   [64];

  typedef struct {
    logic [26:0]  addr1;
    logic [127:0] data1;
    logic [26:0]  addr2;
    logic [127:0] data2;
    logic [15:0]  mask2;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic model_exp(input logic [26:0] addr, input logic [5:0] bc);
    int idx;
    idx = int'(addr[13:4]);
    for (int b = 0; b <= int'(bc); b++) exp_a[b] = ref_mem[(idx + b) % DEPTH];
  endtask

  task automatic wait_cmd_ready(input string nm);
    int t;
    t = 0;
    while (!fifo_cmd_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: fifo_cmd_ready got 0 required 1 within 100 cycles", nm);
    end
  endtask

  // Write burst from wdata_a/wmask_a; later beats carry junk type/addr/burst_cnt
  task automatic do_write(input logic [26:0] addr, input logic [5:0] bc, input int gap_pct);
    int idx;
    idx = int'(addr[13:4]);
    for (int b = 0; b <= int'(bc); b++) begin
      if (b > 0 && gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        fifo_cmd_valid = 1'b0;
        repeat (1 + $urandom_range(2)) tick();
      end
      fifo_cmd_valid     = 1'b1;
      fifo_cmd_type      = (b == 0);
      fifo_cmd_addr      = (b == 0) ? addr : 27'($urandom);
      fifo_cmd_burst_cnt = (b == 0) ? bc : 6'($urandom);
      fifo_cmd_wt_data   = wdata_a[b];
      fifo_cmd_wt_mask   = wmask_a[b];
      wait_cmd_ready("wr_accept");
      tick();
      for (int j = 0; j < 16; j++) begin
        if (!wmask_a[b][j]) ref_mem[(idx + b) % DEPTH][8*j +: 8] = wdata_a[b][8*j +: 8];
      end
    end
    fifo_cmd_valid = 1'b0;
  endtask

  // Read burst compared against exp_a; bp randomises rsp_ready
  task automatic do_read(input logic [26:0] addr, input logic [5:0] bc, input bit bp, input bit timing);
    int cyc, k, n, first_cyc, last_cyc;
    logic stall;
    logic [127:0] held;
    n = int'(bc) + 1;
    fifo_cmd_valid     = 1'b1;
    fifo_cmd_type      = 1'b0;
    fifo_cmd_addr      = addr;
    fifo_cmd_burst_cnt = bc;
    fifo_cmd_wt_mask   = 16'hFFFF;
    wait_cmd_ready("rd_accept");
    tick();
    fifo_cmd_valid = 1'b0;
    cyc = 1; k = 0; first_cyc = -1; last_cyc = -1; stall = 1'b0; held = '0;
    while (k < n && cyc < 1000) begin
      fifo_rsp_ready = bp ? 1'($urandom_range(1)) : 1'b1;
      if (stall) begin
        check("rsp_valid_hold", 128'(fifo_rsp_valid), 128'(1'b1));
        check("rsp_data_hold", fifo_rsp_data, held);
      end
      check("cmd_ready_in_rd", 128'(fifo_cmd_ready), 128'(1'b0));
      if (fifo_rsp_valid && first_cyc < 0) first_cyc = cyc;
      if (fifo_rsp_valid && fifo_rsp_ready) begin
        check("rsp_data", fifo_rsp_data, exp_a[k]);
        k++;
        last_cyc = cyc;
      end
      stall = fifo_rsp_valid && !fifo_rsp_ready;
      held  = fifo_rsp_data;
      tick();
      cyc++;
    end
    if (k < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL rsp_timeout: got %0d beats required %0d", k, n);
    end
    fifo_rsp_ready = 1'b0;
    if (timing) begin
      check("rsp_latency", 128'(first_cyc), 128'(2));
      check("burst_end", 128'(last_cyc), 128'(2 + int'(bc)));
    end
    check("cmd_ready_after", 128'(fifo_cmd_ready), 128'(1'b1));
    check("rsp_valid_after", 128'(fifo_rsp_valid), 128'(1'b0));
    check("busy_after", 128'(busy), 128'(1'b0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    logic [26:0] a;
    logic [5:0]  bc;
    int          k, t;

    vecs[0] = '{27'h0000010, 128'h0123456789ABCDEF0123456789ABCDEF,
                27'h0000010, 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF, 16'hFFFF,
                128'h0123456789ABCDEF0123456789ABCDEF};
    vecs[1] = '{27'h0000050, {16{8'hFF}},
                27'h0000057, 128'h0, 16'h00FF,
                {64'h0, 64'hFFFFFFFFFFFFFFFF}};
    vecs[2] = '{27'h0000070, 128'h0,
                27'h4000070, {16{8'hA5}}, 16'h7FFE,
                {8'hA5, 112'h0, 8'hA5}};
    vecs[3] = '{27'h7FFFFFF, 128'h0,
                27'h0003FF0, {16{8'hFF}}, 16'h0F0F,
                {32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0}};

    n_cmp = 0;
    n_err = 0;
    rst                = 1'b1;
    fifo_cmd_valid     = 1'b0;
    fifo_cmd_type      = 1'b0;
    fifo_cmd_addr      = '0;
    fifo_cmd_burst_cnt = '0;
    fifo_cmd_wt_data   = '0;
    fifo_cmd_wt_mask   = '0;
    fifo_rsp_ready     = 1'b0;
    repeat (3) tick();
    check("reset_cmd_ready", 128'(fifo_cmd_ready), 128'(1'b1));
    check("reset_rsp_valid", 128'(fifo_rsp_valid), 128'(1'b0));
    check("reset_rsp_data", fifo_rsp_data, 128'h0);
    check("reset_busy", 128'(busy), 128'(1'b0));
    rst = 1'b0;
    tick();

    // Fill the whole RAM so every later read has a defined expectation
    for (int blk = 0; blk < 16; blk++) begin
      for (int b = 0; b < 64; b++) begin
        wdata_a[b] = {$urandom, $urandom, $urandom, $urandom};
        wmask_a[b] = 16'h0;
      end
      do_write(27'(blk * 1024), 6'd63, 0);
    end

    // Directed single-beat vectors: full write, masked write, read back
    for (int v = 0; v < 4; v++) begin
      wdata_a[0] = vecs[v].data1;
      wmask_a[0] = 16'h0;
      do_write(vecs[v].addr1, 6'd0, 0);
      wdata_a[0] = vecs[v].data2;
      wmask_a[0] = vecs[v].mask2;
      do_write(vecs[v].addr2, 6'd0, 0);
      exp_a[0] = vecs[v].exp_data;
      do_read(vecs[v].addr1, 6'd0, 1'b0, 1'b1);
    end

    // 64-beat burst wrapping from index 1022 to 0
    for (int b = 0; b < 64; b++) begin
      wdata_a[b] = 128'(b);
      wmask_a[b] = 16'h0;
      exp_a[b]   = 128'(b);
    end
    do_write(27'h0003FE0, 6'd63, 0);
    do_read(27'h0003FE0, 6'd63, 1'b0, 1'b1);

    // Write with valid gaps; beats 1..3 carry type 0
    for (int b = 0; b < 4; b++) begin
      wdata_a[b] = {$urandom, $urandom, $urandom, $urandom};
      wmask_a[b] = 16'h0;
      exp_a[b]   = wdata_a[b];
    end
    do_write(27'h0001230, 6'd3, 70);
    do_read(27'h0001230, 6'd3, 1'b0, 1'b1);

    // 8-beat read under random backpressure
    model_exp(27'h0002000, 6'd7);
    do_read(27'h0002000, 6'd7, 1'b1, 1'b0);

    // Reset after three beats of a 16-beat read
    model_exp(27'h0000400, 6'd15);
    fifo_cmd_valid     = 1'b1;
    fifo_cmd_type      = 1'b0;
    fifo_cmd_addr      = 27'h0000400;
    fifo_cmd_burst_cnt = 6'd15;
    wait_cmd_ready("rst_rd_accept");
    tick();
    fifo_cmd_valid = 1'b0;
    fifo_rsp_ready = 1'b1;
    k = 0;
    t = 0;
    while (k < 3 && t < 100) begin
      if (fifo_rsp_valid) begin
        check("rst_pre_data", fifo_rsp_data, exp_a[k]);
        k++;
      end
      tick();
      t++;
    end
    if (k < 3) begin
      n_cmp++;
      n_err++;
      $display("FAIL rst_pre_timeout: got %0d beats required 3", k);
    end
    rst            = 1'b1;
    fifo_rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_mid_rsp_valid", 128'(fifo_rsp_valid), 128'(1'b0));
    check("rst_mid_cmd_ready", 128'(fifo_cmd_ready), 128'(1'b1));
    check("rst_mid_busy", 128'(busy), 128'(1'b0));
    model_exp(27'h0000420, 6'd0);
    do_read(27'h0000420, 6'd0, 1'b0, 1'b1);

    // Random traffic against the model
    for (int it = 0; it < 40; it++) begin
      a  = 27'($urandom);
      bc = 6'($urandom_range(15));
      if ($urandom_range(1) == 1) begin
        for (int b = 0; b <= int'(bc); b++) begin
          wdata_a[b] = {$urandom, $urandom, $urandom, $urandom};
          case ($urandom_range(3))
            0:       wmask_a[b] = 16'h0000;
            1:       wmask_a[b] = 16'hFFFF;
            default: wmask_a[b] = 16'($urandom);
          endcase
        end
        do_write(a, bc, 30);
      end else begin
        model_exp(a, bc);
        do_read(a, bc, 1'($urandom_range(1)), 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
